// File: rtl/mccu_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states,
// opcode/func constants, datapath mux codes and the instruction decode types.
package mccu_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EXE = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // Don't-care top bits of the logic/arith codes are driven as 0.
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_BR   = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_BRT  = 2'b01;
    localparam logic [1:0] PCS_REGA = 2'b10;
    localparam logic [1:0] PCS_JUMP = 2'b11;

    typedef enum logic [2:0] {
        CLS_RALU    = 3'd0,
        CLS_IALU    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } iclass_e;

    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lui;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_j;
        logic i_jal;
    } instr_t;

    // ALU operation used in EXE for a decoded instruction.
    function automatic logic [3:0] exe_aluc(input instr_t i);
        logic [3:0] a;
        if (i.i_sub || i.i_beq || i.i_bne) a = ALUC_SUB;
        else if (i.i_and || i.i_andi)      a = ALUC_AND;
        else if (i.i_or || i.i_ori)        a = ALUC_OR;
        else if (i.i_xor || i.i_xori)      a = ALUC_XOR;
        else if (i.i_lui)                  a = ALUC_LUI;
        else if (i.i_sll)                  a = ALUC_SLL;
        else if (i.i_srl)                  a = ALUC_SRL;
        else if (i.i_sra)                  a = ALUC_SRA;
        else                               a = ALUC_ADD;
        return a;
    endfunction

endpackage

// File: rtl/mccu_decode.sv
// Combinational op/func decode into one-hot instruction flags and an
// instruction class used by the control FSM.
module mccu_decode
    import mccu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output instr_t     instr,
    output iclass_e    iclass
);

    logic rtype_s;

    assign rtype_s = (op == OP_RTYPE);

    // One-hot instruction flags.
    always_comb begin
        instr        = '0;
        instr.i_add  = rtype_s && (func == FN_ADD);
        instr.i_sub  = rtype_s && (func == FN_SUB);
        instr.i_and  = rtype_s && (func == FN_AND);
        instr.i_or   = rtype_s && (func == FN_OR);
        instr.i_xor  = rtype_s && (func == FN_XOR);
        instr.i_sll  = rtype_s && (func == FN_SLL);
        instr.i_srl  = rtype_s && (func == FN_SRL);
        instr.i_sra  = rtype_s && (func == FN_SRA);
        instr.i_jr   = rtype_s && (func == FN_JR);
        instr.i_addi = (op == OP_ADDI);
        instr.i_andi = (op == OP_ANDI);
        instr.i_ori  = (op == OP_ORI);
        instr.i_xori = (op == OP_XORI);
        instr.i_lui  = (op == OP_LUI);
        instr.i_lw   = (op == OP_LW);
        instr.i_sw   = (op == OP_SW);
        instr.i_beq  = (op == OP_BEQ);
        instr.i_bne  = (op == OP_BNE);
        instr.i_j    = (op == OP_J);
        instr.i_jal  = (op == OP_JAL);
    end

    // Instruction class; anything not in the subset is illegal and runs as a nop.
    always_comb begin
        iclass = CLS_ILLEGAL;
        if (instr.i_add || instr.i_sub || instr.i_and || instr.i_or || instr.i_xor ||
            instr.i_sll || instr.i_srl || instr.i_sra) begin
            iclass = CLS_RALU;
        end else if (instr.i_addi || instr.i_andi || instr.i_ori || instr.i_xori ||
                     instr.i_lui) begin
            iclass = CLS_IALU;
        end else if (instr.i_lw) begin
            iclass = CLS_LOAD;
        end else if (instr.i_sw) begin
            iclass = CLS_STORE;
        end else if (instr.i_beq || instr.i_bne) begin
            iclass = CLS_BRANCH;
        end else if (instr.i_j || instr.i_jal || instr.i_jr) begin
            iclass = CLS_JUMP;
        end else begin
            iclass = CLS_ILLEGAL;
        end
    end

endmodule

// File: rtl/mccu_fsm.sv
// Multicycle control unit: IF/ID/EXE/MEM/WB sequencer with a request/ready
// memory handshake, driving all datapath strobes combinationally.
module mccu_fsm
    import mccu_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       iord,
    output logic       wmem,
    output logic       wir,
    output logic       wpc,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state
);

    state_e  state_r;
    state_e  next_state_s;
    instr_t  instr_s;
    iclass_e iclass_s;

    logic       mem_req_s, wmem_s, wir_s, wpc_s, wreg_s;
    logic       iord_s, regrt_s, m2reg_s, jal_s, shift_s, alusrca_s, sext_s;
    logic [1:0] alusrcb_s, pcsource_s;
    logic [3:0] aluc_s;

    mccu_decode u_decode (
        .op     (op),
        .func   (func),
        .instr  (instr_s),
        .iclass (iclass_s)
    );

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= ST_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and per-state strobes.
    always_comb begin
        next_state_s = ST_IF;
        mem_req_s    = 1'b0;
        wmem_s       = 1'b0;
        wir_s        = 1'b0;
        wpc_s        = 1'b0;
        wreg_s       = 1'b0;
        iord_s       = 1'b0;
        regrt_s      = 1'b0;
        m2reg_s      = 1'b0;
        jal_s        = 1'b0;
        shift_s      = 1'b0;
        alusrca_s    = 1'b0;
        sext_s       = 1'b0;
        alusrcb_s    = ALUB_REG;
        pcsource_s   = PCS_ALU;
        aluc_s       = ALUC_ADD;
        case (state_r)
            ST_IF: begin
                mem_req_s = 1'b1;
                alusrcb_s = ALUB_FOUR;
                if (mem_rdy) begin
                    wir_s        = 1'b1;
                    wpc_s        = 1'b1;
                    next_state_s = ST_ID;
                end else begin
                    next_state_s = ST_IF;
                end
            end
            ST_ID: begin
                // The ALU precomputes the branch target while decode settles.
                alusrcb_s = ALUB_BR;
                sext_s    = 1'b1;
                if (iclass_s == CLS_JUMP) begin
                    wpc_s        = 1'b1;
                    next_state_s = ST_IF;
                    if (instr_s.i_jr) begin
                        pcsource_s = PCS_REGA;
                    end else begin
                        pcsource_s = PCS_JUMP;
                        wreg_s     = instr_s.i_jal;
                        jal_s      = instr_s.i_jal;
                    end
                end else if (iclass_s == CLS_ILLEGAL) begin
                    next_state_s = ST_IF;
                end else begin
                    next_state_s = ST_EXE;
                end
            end
            ST_EXE: begin
                case (iclass_s)
                    CLS_RALU: begin
                        alusrca_s    = 1'b1;
                        shift_s      = instr_s.i_sll || instr_s.i_srl || instr_s.i_sra;
                        aluc_s       = exe_aluc(instr_s);
                        next_state_s = ST_WB;
                    end
                    CLS_IALU: begin
                        alusrcb_s    = ALUB_IMM;
                        sext_s       = instr_s.i_addi;
                        aluc_s       = exe_aluc(instr_s);
                        next_state_s = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alusrcb_s    = ALUB_IMM;
                        sext_s       = 1'b1;
                        next_state_s = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        aluc_s       = ALUC_SUB;
                        pcsource_s   = PCS_BRT;
                        wpc_s        = instr_s.i_beq ? z : ~z;
                        next_state_s = ST_IF;
                    end
                    default: begin
                        next_state_s = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                wmem_s    = (iclass_s == CLS_STORE);
                if (mem_rdy) begin
                    next_state_s = (iclass_s == CLS_LOAD) ? ST_WB : ST_IF;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB: begin
                wreg_s       = 1'b1;
                regrt_s      = (iclass_s == CLS_IALU) || (iclass_s == CLS_LOAD);
                m2reg_s      = (iclass_s == CLS_LOAD);
                next_state_s = ST_IF;
            end
            default: begin
                next_state_s = ST_IF;
            end
        endcase
    end

    // Write strobes and the request fall with clrn so no partial access escapes.
    assign mem_req  = mem_req_s & clrn;
    assign wmem     = wmem_s & clrn;
    assign wir      = wir_s & clrn;
    assign wpc      = wpc_s & clrn;
    assign wreg     = wreg_s & clrn;
    assign iord     = iord_s;
    assign regrt    = regrt_s;
    assign m2reg    = m2reg_s;
    assign jal      = jal_s;
    assign shift    = shift_s;
    assign alusrca  = alusrca_s;
    assign alusrcb  = alusrcb_s;
    assign sext     = sext_s;
    assign aluc     = aluc_s;
    assign pcsource = pcsource_s;
    assign state    = state_r;

endmodule

// File: tb/tb_mccu_fsm.sv
// Bench for mccu_fsm: builds the expected per-cycle strobe sequence of each
// instruction from the instruction's behaviour and compares every cycle.
module tb_mccu_fsm;

    logic       clk = 1'b0;
    logic       clrn;
    logic [5:0] op, func;
    logic       z, mem_rdy;
    logic       mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal, shift, alusrca, sext;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int cur_k = 0;

    typedef struct {
        logic       mem_rdy, z;
        logic [2:0] st;
        logic       mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal, shift, alusrca, sext;
        logic [1:0] alusrcb, pcsource;
        logic [3:0] aluc;
    } rec_t;

    mccu_fsm dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .iord(iord), .wmem(wmem), .wir(wir), .wpc(wpc), .wreg(wreg),
        .regrt(regrt), .m2reg(m2reg), .jal(jal), .shift(shift), .alusrca(alusrca),
        .alusrcb(alusrcb), .sext(sext), .aluc(aluc), .pcsource(pcsource), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s (cycle %0d, instr %0d): got %h, expected %h", name, cyc_n, cur_k, got, want);
        end
    endtask

    // kind: 0 R-ALU, 1 I-ALU, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 jal, 8 jr, 9 illegal
    task automatic lookup(input int k, output logic [5:0] o, output logic [5:0] f,
                          output int kind, output logic [3:0] ac);
        f  = 6'($urandom_range(0, 63));
        ac = 4'b0000;
        case (k)
            0:  begin o = 6'b000000; f = 6'b100000; kind = 0; ac = 4'b0000; end
            1:  begin o = 6'b000000; f = 6'b100010; kind = 0; ac = 4'b0100; end
            2:  begin o = 6'b000000; f = 6'b100100; kind = 0; ac = 4'b0001; end
            3:  begin o = 6'b000000; f = 6'b100101; kind = 0; ac = 4'b0101; end
            4:  begin o = 6'b000000; f = 6'b100110; kind = 0; ac = 4'b0010; end
            5:  begin o = 6'b000000; f = 6'b000000; kind = 0; ac = 4'b0011; end
            6:  begin o = 6'b000000; f = 6'b000010; kind = 0; ac = 4'b0111; end
            7:  begin o = 6'b000000; f = 6'b000011; kind = 0; ac = 4'b1111; end
            8:  begin o = 6'b000000; f = 6'b001000; kind = 8; end
            9:  begin o = 6'b001000; kind = 1; ac = 4'b0000; end
            10: begin o = 6'b001100; kind = 1; ac = 4'b0001; end
            11: begin o = 6'b001101; kind = 1; ac = 4'b0101; end
            12: begin o = 6'b001110; kind = 1; ac = 4'b0010; end
            13: begin o = 6'b001111; kind = 1; ac = 4'b0110; end
            14: begin o = 6'b100011; kind = 2; end
            15: begin o = 6'b101011; kind = 3; end
            16: begin o = 6'b000100; kind = 4; end
            17: begin o = 6'b000101; kind = 5; end
            18: begin o = 6'b000010; kind = 6; end
            19: begin o = 6'b000011; kind = 7; end
            20: begin o = 6'b111111; kind = 9; end
            default: begin o = 6'b000000; f = 6'b111111; kind = 9; end
        endcase
    endtask

    function automatic rec_t blank(input logic [2:0] st);
        rec_t r;
        r = '{default: '0};
        r.st      = st;
        r.mem_rdy = 1'($urandom_range(0, 1));
        r.z       = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic compare(input rec_t r);
        logic [3:0] m;
        // Arithmetic/logic ALU codes leave bit 3 unspecified; shifts use all four bits.
        m = (r.aluc[1:0] == 2'b11) ? 4'hF : 4'h7;
        chk("state", {1'b0, state}, {1'b0, r.st});
        chk("mem_req", {3'b0, mem_req}, {3'b0, r.mem_req});
        chk("iord", {3'b0, iord}, {3'b0, r.iord});
        chk("wmem", {3'b0, wmem}, {3'b0, r.wmem});
        chk("wir", {3'b0, wir}, {3'b0, r.wir});
        chk("wpc", {3'b0, wpc}, {3'b0, r.wpc});
        chk("wreg", {3'b0, wreg}, {3'b0, r.wreg});
        chk("regrt", {3'b0, regrt}, {3'b0, r.regrt});
        chk("m2reg", {3'b0, m2reg}, {3'b0, r.m2reg});
        chk("jal", {3'b0, jal}, {3'b0, r.jal});
        chk("shift", {3'b0, shift}, {3'b0, r.shift});
        chk("alusrca", {3'b0, alusrca}, {3'b0, r.alusrca});
        chk("sext", {3'b0, sext}, {3'b0, r.sext});
        chk("alusrcb", {2'b0, alusrcb}, {2'b0, r.alusrcb});
        chk("pcsource", {2'b0, pcsource}, {2'b0, r.pcsource});
        chk("aluc", aluc & m, r.aluc & m);
    endtask

    // Builds the expected cycle list of one instruction, then drives and checks it.
    // abort_at >= 0 pulses clrn low in that cycle and abandons the instruction.
    task automatic run_instr(input int k, input int ifw, input int memw, input logic zv,
                             input int abort_at, output int len);
        logic [5:0] o, f;
        int         kind;
        logic [3:0] ac;
        rec_t       r;
        rec_t       q[$];
        lookup(k, o, f, kind, ac);
        cur_k = k;
        op    = o;
        func  = f;
        for (int i = 0; i <= ifw; i++) begin
            r = blank(3'd0);
            r.mem_rdy = (i == ifw);
            r.mem_req = 1'b1;
            r.alusrcb = 2'b01;
            r.wir     = r.mem_rdy;
            r.wpc     = r.mem_rdy;
            q.push_back(r);
        end
        r = blank(3'd1);
        r.alusrcb = 2'b11;
        r.sext    = 1'b1;
        if (kind == 6 || kind == 7) begin
            r.wpc = 1'b1; r.pcsource = 2'b11;
            r.wreg = (kind == 7); r.jal = (kind == 7);
        end
        if (kind == 8) begin
            r.wpc = 1'b1; r.pcsource = 2'b10;
        end
        q.push_back(r);
        if (kind < 6) begin
            r = blank(3'd2);
            r.aluc = ac;
            if (kind == 0) begin
                r.alusrca = 1'b1;
                r.shift   = (k >= 5 && k <= 7);
            end else if (kind == 1) begin
                r.alusrcb = 2'b10;
                r.sext    = (k == 9);
            end else if (kind == 2 || kind == 3) begin
                r.alusrcb = 2'b10;
                r.sext    = 1'b1;
            end else begin
                r.z        = zv;
                r.aluc     = 4'b0100;
                r.pcsource = 2'b01;
                r.wpc      = (kind == 4) ? zv : ~zv;
            end
            q.push_back(r);
            if (kind == 2 || kind == 3) begin
                for (int i = 0; i <= memw; i++) begin
                    r = blank(3'd3);
                    r.mem_rdy = (i == memw);
                    r.mem_req = 1'b1;
                    r.iord    = 1'b1;
                    r.wmem    = (kind == 3);
                    q.push_back(r);
                end
            end
            if (kind <= 2) begin
                r = blank(3'd4);
                r.wreg  = 1'b1;
                r.regrt = (kind != 0);
                r.m2reg = (kind == 2);
                q.push_back(r);
            end
        end
        len = q.size();
        for (int i = 0; i < len; i++) begin
            mem_rdy = q[i].mem_rdy;
            z       = q[i].z;
            @(negedge clk);
            compare(q[i]);
            if (i == abort_at) begin
                #2 clrn = 1'b0;
                #1;
                chk("rst_state", {1'b0, state}, 4'h0);
                chk("rst_mem_req", {3'b0, mem_req}, 4'h0);
                chk("rst_wmem", {3'b0, wmem}, 4'h0);
                @(posedge clk);
                #1;
                chk("rst_hold_state", {1'b0, state}, 4'h0);
                chk("rst_hold_req", {3'b0, mem_req}, 4'h0);
                clrn = 1'b1;
                cyc_n++;
                return;
            end
            @(posedge clk);
            #1;
            cyc_n++;
        end
    endtask

    initial begin
        int len;
        clrn    = 1'b0;
        op      = 6'b000000;
        func    = 6'b000000;
        z       = 1'b0;
        mem_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {1'b0, state}, 4'h0);
        chk("reset_mem_req", {3'b0, mem_req}, 4'h0);
        chk("reset_wir", {3'b0, wir}, 4'h0);
        chk("reset_wpc", {3'b0, wpc}, 4'h0);
        chk("reset_wreg", {3'b0, wreg}, 4'h0);
        chk("reset_wmem", {3'b0, wmem}, 4'h0);
        chk("reset_alusrcb", {2'b0, alusrcb}, 4'h1);
        chk("reset_iord", {3'b0, iord}, 4'h0);
        @(posedge clk);
        #1 clrn = 1'b1;

        run_instr(0, 0, 0, 1'b0, -1, len);  chk("len_add", 4'(len), 4'd4);
        run_instr(14, 2, 3, 1'b0, -1, len); chk("len_lw_waits", 4'(len), 4'd10);
        run_instr(16, 0, 0, 1'b1, -1, len); chk("len_beq_z1", 4'(len), 4'd3);
        run_instr(16, 0, 0, 1'b0, -1, len);
        run_instr(17, 0, 0, 1'b1, -1, len);
        run_instr(17, 0, 0, 1'b0, -1, len);
        run_instr(19, 0, 0, 1'b0, -1, len); chk("len_jal", 4'(len), 4'd2);
        run_instr(15, 0, 0, 1'b0, -1, len); chk("len_sw", 4'(len), 4'd4);
        run_instr(15, 1, 3, 1'b0, 4, len);
        run_instr(20, 0, 0, 1'b0, -1, len); chk("len_illegal", 4'(len), 4'd2);
        run_instr(3, 0, 0, 1'b0, -1, len);
        run_instr(13, 1, 0, 1'b0, -1, len);

        for (int n = 0; n < 300; n++) begin
            run_instr($urandom_range(0, 21), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), -1, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mccu_fsm.md
# mccu_fsm

Multicycle control unit for the MIPS-subset CPU. It sequences a shared-memory, multicycle datapath through fetch, decode, execute, memory and write-back states, with a request/ready handshake to variable-latency memory. It sits beside the datapath and drives the PC, IR, register-file, ALU-mux and memory strobes every cycle. It supports the same 20-instruction subset as the single-cycle controller.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- op  in  6  IR[31:26]; stable from the cycle after wir.
- func  in  6  IR[5:0].
- z  in  1  ALU zero flag, combinational from the current ALU operation.
- mem_rdy  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request; held until mem_rdy.
- iord  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- wmem  out  1  memory write; asserted only together with mem_req.
- wir  out  1  IR write enable.
- wpc  out  1  PC write enable.
- wreg  out  1  register-file write enable.
- regrt  out  1  destination select: 1 = rt, 0 = rd.
- m2reg  out  1  write-back source: 1 = memory data register.
- jal  out  1  force destination $31 and data PC.
- shift  out  1  ALU A = shamt.
- alusrca  out  1  ALU A: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B: 00 = reg B, 01 = 4, 10 = extended imm, 11 = sext imm << 2.
- sext  out  1  sign-extend imm (else zero-extend).
- aluc  out  4  ALU op: add x000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111.
- pcsource  out  2  00 = ALU result, 01 = ALU-out register (branch target), 10 = register A (jr), 11 = jump address.
- state  out  3  current state, for debug.

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5–7 are illegal and go to IF on the next cycle with all strobes 0.
- IF:
  - Drives mem_req=1, iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - On mem_rdy: wir=1 and wpc=1 for one cycle, then go to ID.
  - Without mem_rdy: stay in IF with wir=0 and wpc=0.
- ID:
  - ALU computes the branch target: alusrca=0, alusrcb=11, sext=1, aluc=add.
  - j: wpc=1, pcsource=11, then IF.
  - jal: additionally wreg=1 and jal=1.
  - jr: wpc=1, pcsource=10, then IF.
  - Undecoded op/func: no strobes, then IF (executes as a nop).
  - All other instructions go to EXE.
- EXE:
  - R-type: alusrca=1 (shift=1 for sll/srl/sra), alusrcb=00, then WB.
  - addi/andi/ori/xori/lui: alusrcb=10, sext=1 only for addi, then WB.
  - lw/sw: alusrcb=10, sext=1, aluc=add, then MEM.
  - beq: aluc=sub, alusrcb=00, pcsource=01, wpc=z. bne: same with wpc=~z. Both then go to IF.
- MEM:
  - mem_req=1, iord=1, wmem=1 for sw.
  - Stays in MEM until mem_rdy.
  - On mem_rdy: sw goes to IF, lw goes to WB.
- WB:
  - wreg=1.
  - regrt=1 for I-type, m2reg=1 for lw.
  - Then IF.
- Strobe rules:
  - All strobes are combinational from state, op, func, z and mem_rdy.
  - Strobes not named for a state are 0.

## Timing
- Reset while clrn=0:
  - state=IF.
  - All write strobes (wir, wpc, wreg, wmem) and mem_req are forced to 0. Mux selects and aluc take their IF values.
- Reset release: the first fetch request is issued in the first cycle with clrn=1.
- Cycles per instruction with zero wait states:
  - j/jal/jr and unknown instructions: 2.
  - beq/bne: 3.
  - ALU and sw: 4.
  - lw: 5.
  - Each cycle mem_rdy is low adds 1 cycle to IF or MEM.
- Reset mid-access:
  - State returns to IF immediately; mem_req drops asynchronously.
  - No partial write is issued, since wmem falls with clrn.
- mem_rdy outside IF/MEM is ignored.
- z is used only in EXE for beq/bne and must settle within that cycle.

## Structure
- Package mccu_pkg holds:
  - state encodings;
  - opcode and func constants;
  - aluc, alusrcb and pcsource encodings.
- Sub-module mccu_decode: combinational op/func decode producing one-hot instruction flags and a class (R-ALU, I-ALU, load, store, branch, jump, illegal).
- mccu_fsm holds the state register and output logic.

## Test plan
- Reset release, mem_rdy=1 → IF(wir=1, wpc=1) → ID → EXE → WB(wreg=1, regrt=0) for add $3,$1,$2; 4 cycles.
- lw with mem_rdy low 2 cycles in IF and 3 in MEM → 10 cycles total; wmem=0 throughout; m2reg=1 and regrt=1 in WB.
- beq:
  - with z=1 in EXE → wpc=1, pcsource=01;
  - with z=0 → wpc=0;
  - bne the reverse.
- jal → ID asserts wpc=1, pcsource=11, wreg=1, jal=1 → next state IF after 2 cycles.
- sw with clrn pulsed low during MEM → mem_req=0 and wmem=0 immediately; state=IF; refetch follows.
- op=6'b111111 → ID to IF with no strobes asserted; next instruction fetched normally.
